// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out serializer. Takes an N-bit word over a valid/ready
// handshake and shifts it out one bit per enabled clock, LSB first. A
// downstream right-shift SIPO with its serial input driven from sout collects
// the word back in its original bit order after N enabled edges.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   din         in   [N-1:0] word to transmit, sampled only on accept
//   load_valid  in   producer presents a word on din
//   load_ready  out  serializer can take a word this cycle (combinational)
//   shift_en    in   advance the serial stream by one bit (link pacing)
//   sout        out  serial data bit, LSB of the current word first
//   sout_valid  out  sout carries a valid bit
//   last        out  sout is bit N-1 of the current word
//   busy        out  a word is held and not yet fully shifted
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q,   cnt_d;

  logic at_last;
  logic accept;

  // Final bit of the current word is on the wire.
  assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // Ready in IDLE, or on the edge that consumes the final bit so the next
  // word follows with no bubble. Held low while reset is asserted so that a
  // producer never sees a handshake that the reset would swallow.
  assign load_ready = !reset && ((state_q == IDLE) || (at_last && shift_en));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (shift_en) begin
          if (at_last) begin
            if (accept) begin
              // Back-to-back reload on the final-shift edge.
              shreg_d = din;
              cnt_d   = '0;
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = {1'b0, shreg_q[N-1:1]};
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // clears them without waiting for a clock edge.
  assign busy       = (state_q == SHIFT);
  assign sout_valid = busy;
  assign sout       = busy && shreg_q[0];
  assign last       = at_last;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         shift_en;
  logic         sout;
  logic         sout_valid;
  logic         last;
  logic         busy;

  always #5 clk = ~clk;

  piso_serializer #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last),
    .busy       (busy)
  );

  // Receiving right-shift SIPO, clocked only on enabled edges.
  logic [N-1:0] sipo;
  always @(posedge clk) begin
    if (shift_en) sipo <= {sout, sipo[N-1:1]};
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: the bits still to be transmitted, oldest first.
  // The wire shows the head of the queue; the final bit of a word is on the
  // wire exactly when one bit remains.
  bit mq[$];

  logic obs_sout, obs_valid, obs_last, obs_busy, obs_ready;

  typedef struct {
    logic         lv;
    logic [N-1:0] d;
    logic         se;
    logic         es;
    logic         ev;
    logic         el;
    logic         er;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic lv, input logic [N-1:0] d, input logic se,
                     input logic es, input logic ev, input logic el, input logic er);
    vecs.push_back('{lv, d, se, es, ev, el, er});
  endtask

  // One clock cycle: drive inputs just after a rising edge, compare at the
  // falling edge, then let the model advance on the next rising edge.
  task automatic cycle(input logic lv, input logic [N-1:0] d, input logic se, input logic rst);
    logic m_ready;
    logic m_sout;
    load_valid = lv;
    din        = d;
    shift_en   = se;
    reset      = rst;
    if (rst) mq.delete();
    @(negedge clk);
    m_ready = !rst && (mq.size() == 0 || (mq.size() == 1 && se));
    m_sout  = (mq.size() > 0) ? mq[0] : 1'b0;
    obs_sout  = sout;
    obs_valid = sout_valid;
    obs_last  = last;
    obs_busy  = busy;
    obs_ready = load_ready;
    chk("model_sout",  obs_sout,  m_sout);
    chk("model_valid", obs_valid, mq.size() > 0);
    chk("model_busy",  obs_busy,  mq.size() > 0);
    chk("model_last",  obs_last,  mq.size() == 1);
    chk("model_ready", obs_ready, m_ready);
    @(posedge clk);
    if (!rst) begin
      if (se && mq.size() > 0) void'(mq.pop_front());
      if (lv && m_ready) begin
        for (int i = 0; i < N; i++) mq.push_back(d[i]);
        $display("accept word 0x%h", d);
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] got;
    int           nlast;
    logic [N-1:0] rnd_din;

    // ---------------- reset ----------------
    reset      = 1'b1;
    load_valid = 1'b1;
    din        = 4'hF;
    shift_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sout",  sout,       1'b0);
    chk("rst_valid", sout_valid, 1'b0);
    chk("rst_last",  last,       1'b0);
    chk("rst_busy",  busy,       1'b0);
    chk("rst_ready", load_ready, 1'b0);

    // ---------------- table-driven vectors ----------------
    // basic word 1011
    add(1, 4'hB, 1, 0, 0, 0, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 1, 1);
    add(0, 4'h0, 1, 0, 0, 0, 1);
    // back-to-back A then 5
    add(1, 4'hA, 1, 0, 0, 0, 1);
    add(1, 4'h5, 1, 0, 1, 0, 0);
    add(1, 4'h5, 1, 1, 1, 0, 0);
    add(1, 4'h5, 1, 0, 1, 0, 0);
    add(1, 4'h5, 1, 1, 1, 1, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 1, 1);
    add(0, 4'h0, 1, 0, 0, 0, 1);
    // pacing 1001 with shift_en low 3 cycles on bit 1
    add(1, 4'h9, 1, 0, 0, 0, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 1, 1);
    add(0, 4'h0, 1, 0, 0, 0, 1);
    // backpressure: F ignored mid-word, 3 accepted on the final shift
    add(1, 4'h6, 1, 0, 0, 0, 1);
    add(1, 4'hF, 1, 0, 1, 0, 0);
    add(1, 4'hF, 1, 1, 1, 0, 0);
    add(1, 4'h3, 1, 1, 1, 0, 0);
    add(1, 4'h3, 1, 0, 1, 1, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 1, 1);
    add(0, 4'h0, 1, 0, 0, 0, 1);
    // final bit held by shift_en low, then reload of 7
    add(1, 4'h1, 1, 0, 0, 0, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(1, 4'h7, 0, 0, 1, 1, 0);
    add(1, 4'h7, 1, 0, 1, 1, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 1, 1);
    add(0, 4'h0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      cycle(vecs[i].lv, vecs[i].d, vecs[i].se, 1'b0);
      chk($sformatf("vec%0d_sout",  i), obs_sout,  vecs[i].es);
      chk($sformatf("vec%0d_valid", i), obs_valid, vecs[i].ev);
      chk($sformatf("vec%0d_busy",  i), obs_busy,  vecs[i].ev);
      chk($sformatf("vec%0d_last",  i), obs_last,  vecs[i].el);
      chk($sformatf("vec%0d_ready", i), obs_ready, vecs[i].er);
    end

    // ---------------- loopback into SIPO ----------------
    cycle(1'b1, 4'b0110, 1'b1, 1'b0);
    repeat (N) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk("loopback_sipo", sipo, 4'b0110);

    // ---------------- reset mid-word ----------------
    cycle(1'b1, 4'hD, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    // bit 2 of 1101 is now on the wire
    #1;
    chk("midrst_pre_sout",  sout,       1'b1);
    chk("midrst_pre_valid", sout_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_sout",  sout,       1'b0);
    chk("midrst_valid", sout_valid, 1'b0);
    chk("midrst_last",  last,       1'b0);
    chk("midrst_busy",  busy,       1'b0);
    chk("midrst_ready", load_ready, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    cycle(1'b1, 4'hF, 1'b1, 1'b1);
    cycle(1'b1, 4'h2, 1'b1, 1'b0);
    chk("restart_ready", obs_ready, 1'b1);
    nlast = 0;
    got   = '0;
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      got[i] = obs_sout;
      if (obs_last) nlast++;
    end
    chk("restart_word",  got,   4'h2);
    chk("restart_last",  obs_last, 1'b1);
    chk("restart_nlast", nlast, 1);

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 600; i++) begin
      rnd_din = N'($urandom);
      cycle(1'($urandom_range(0, 1)), rnd_din, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 99) == 0));
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
